// File: rtl/time_pkg.sv
// Shared BCD time types, field limits and digit helpers for the time_keeper slice.
package time_pkg;

  typedef logic [7:0] bcd_t;

  localparam bcd_t SEC_MAX  = 8'h59;
  localparam bcd_t MIN_MAX  = 8'h59;
  localparam bcd_t HOUR_MAX = 8'h23;
  localparam bcd_t BCD_ZERO = 8'h00;

  // Both nibbles must be decimal digits before the packed compare against max means anything.
  function automatic logic bcd_legal(input bcd_t v, input bcd_t max);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t max);
    bcd_t r;
    if (v == max) begin
      r = BCD_ZERO;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter wrapping at MAX; load has priority over increment.
module bcd_mod_counter
  import time_pkg::*;
#(
  parameter bcd_t MAX     = 8'h59,
  parameter bcd_t RST_VAL = 8'h00
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t value,
  output logic carry
);

  bcd_t r_value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= RST_VAL;
    end else if (load) begin
      r_value <= load_val;
    end else if (inc) begin
      r_value <= bcd_inc(r_value, MAX);
    end
  end

  assign value = r_value;
  assign carry = inc && !load && (r_value == MAX);

endmodule

// File: rtl/time_keeper.sv
// BCD hh:mm:ss clock advanced by rising edges of an asynchronous 1 Hz tick.
// Optional alarm logic is built only when TIME_KEEPER_ALARM_EN is defined.
module time_keeper
  import time_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter bcd_t RESET_HH    = 8'h00
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic tick_1Hz,
  input  logic load_valid,
  input  bcd_t load_hh,
  input  bcd_t load_mm,
  input  bcd_t load_ss,
  output logic load_ready,
  output logic load_err,
  output bcd_t hh_bcd,
  output bcd_t mm_bcd,
  output bcd_t ss_bcd,
  output logic sec_pulse,
  output logic day_pulse,
  input  logic alarm_wr,
  input  bcd_t alarm_hh,
  input  bcd_t alarm_mm,
  input  logic alarm_on,
  input  logic alarm_ack,
  output logic alarm_ring
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic r_hist;
  logic r_armed;
  logic r_load_ready;
  logic r_sec_pulse;
  logic r_day_pulse;
  logic r_load_err;

  logic w_sync;
  logic w_sync_vld;
  logic w_rise;
  logic w_load_acc;
  logic w_load_legal;
  logic w_load_ok;
  logic w_adv;
  bcd_t w_hh;
  bcd_t w_mm;
  bcd_t w_ss;
  logic w_ss_carry;
  logic w_mm_carry;
  logic w_hh_carry;

  // The valid chain marks stages holding real samples rather than reset zeros, so
  // arming needs a genuinely sampled low before any rise can count.
  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_sync_vld <= '0;
      r_hist     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], tick_1Hz};
      r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_hist     <= w_sync;
      if (w_sync_vld && !w_sync) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_sync_vld = r_sync_vld[SYNC_STAGES-1];
  assign w_rise     = w_sync && !r_hist && r_armed;

  assign w_load_acc   = load_valid && r_load_ready;
  assign w_load_legal = bcd_legal(load_hh, HOUR_MAX) && bcd_legal(load_mm, MIN_MAX) &&
                        bcd_legal(load_ss, SEC_MAX);
  assign w_load_ok    = w_load_acc && w_load_legal;
  assign w_adv        = w_rise && !w_load_ok;

  bcd_mod_counter #(.MAX(SEC_MAX), .RST_VAL(BCD_ZERO)) u_ss (
    .clk(clk_50MHz), .rst_n(rst_n), .inc(w_adv), .load(w_load_ok),
    .load_val(load_ss), .value(w_ss), .carry(w_ss_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX), .RST_VAL(BCD_ZERO)) u_mm (
    .clk(clk_50MHz), .rst_n(rst_n), .inc(w_ss_carry), .load(w_load_ok),
    .load_val(load_mm), .value(w_mm), .carry(w_mm_carry)
  );

  bcd_mod_counter #(.MAX(HOUR_MAX), .RST_VAL(RESET_HH)) u_hh (
    .clk(clk_50MHz), .rst_n(rst_n), .inc(w_mm_carry), .load(w_load_ok),
    .load_val(load_hh), .value(w_hh), .carry(w_hh_carry)
  );

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      r_load_ready <= 1'b0;
      r_sec_pulse  <= 1'b0;
      r_day_pulse  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_load_ready <= 1'b1;
      r_sec_pulse  <= w_adv;
      r_day_pulse  <= w_hh_carry;
      r_load_err   <= w_load_acc && !w_load_legal;
    end
  end

  assign load_ready = r_load_ready;
  assign load_err   = r_load_err;
  assign sec_pulse  = r_sec_pulse;
  assign day_pulse  = r_day_pulse;
  assign hh_bcd     = w_hh;
  assign mm_bcd     = w_mm;
  assign ss_bcd     = w_ss;

`ifdef TIME_KEEPER_ALARM_EN
  bcd_t r_alarm_hh;
  bcd_t r_alarm_mm;
  logic r_changed;
  logic r_ring;
  logic w_alarm_match;

  // Match is taken on the registered time in the cycle after it changed, so the
  // ring rises one cycle after the matching time first appears.
  assign w_alarm_match = r_changed && alarm_on && (w_hh == r_alarm_hh) &&
                         (w_mm == r_alarm_mm) && (w_ss == BCD_ZERO);

  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      r_alarm_hh <= BCD_ZERO;
      r_alarm_mm <= BCD_ZERO;
      r_changed  <= 1'b0;
      r_ring     <= 1'b0;
    end else begin
      if (alarm_wr && bcd_legal(alarm_hh, HOUR_MAX) && bcd_legal(alarm_mm, MIN_MAX)) begin
        r_alarm_hh <= alarm_hh;
        r_alarm_mm <= alarm_mm;
      end
      r_changed <= w_adv || w_load_ok;
      r_ring    <= alarm_on && !alarm_ack && (r_ring || w_alarm_match);
    end
  end

  assign alarm_ring = r_ring;
`else
  logic w_unused_alarm;
  assign w_unused_alarm = ^{alarm_wr, alarm_hh, alarm_mm, alarm_on, alarm_ack};
  assign alarm_ring     = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// Randomized bench for time_keeper against a seconds-of-day reference model.
module tb_time_keeper;

  localparam logic [7:0] RST_HH = 8'h08;

  logic       clk_50MHz = 1'b0;
  logic       rst_n;
  logic       tick_1Hz;
  logic       load_valid;
  logic [7:0] load_hh, load_mm, load_ss;
  logic       load_ready, load_err;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       sec_pulse, day_pulse;
  logic       alarm_wr;
  logic [7:0] alarm_hh, alarm_mm;
  logic       alarm_on, alarm_ack, alarm_ring;

  int errors = 0;
  int checks = 0;

  // Reference model state: time as seconds since midnight plus recent tick samples.
  int m_t;
  int m_since;
  bit m_s1, m_s2, m_s3;
  bit m_ready, m_sec, m_day, m_err, m_ring, m_changed;
  int m_ahh, m_amm;

  always #10 clk_50MHz = ~clk_50MHz;

  time_keeper #(.SYNC_STAGES(2), .RESET_HH(RST_HH)) dut (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .tick_1Hz(tick_1Hz),
    .load_valid(load_valid), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .load_ready(load_ready), .load_err(load_err),
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse),
    .alarm_wr(alarm_wr), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_on(alarm_on), .alarm_ack(alarm_ack), .alarm_ring(alarm_ring)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit legal(input logic [7:0] b, input int max);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (bcd2int(b) <= max);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // A second is counted when the sample two edges back was high, the one before it
  // was low, and that low sample was taken after the most recent reset.
  task automatic model_step();
    bit adv, acc, ok, al_match;
    if (!rst_n) begin
      m_t = bcd2int(RST_HH) * 3600;
      m_since = 0;
      {m_ready, m_sec, m_day, m_err, m_ring, m_changed} = '0;
      m_ahh = 0;
      m_amm = 0;
    end else begin
      if (m_since < 100) m_since++;
      adv = (m_since >= 4) && m_s2 && !m_s3;
      acc = load_valid && m_ready;
      ok  = acc && legal(load_hh, 23) && legal(load_mm, 59) && legal(load_ss, 59);
      al_match = m_changed && alarm_on && (m_t == m_ahh * 3600 + m_amm * 60);
`ifdef TIME_KEEPER_ALARM_EN
      m_ring = alarm_on && !alarm_ack && (m_ring || al_match);
      if (alarm_wr && legal(alarm_hh, 23) && legal(alarm_mm, 59)) begin
        m_ahh = bcd2int(alarm_hh);
        m_amm = bcd2int(alarm_mm);
      end
`else
      m_ring = al_match && 1'b0;
`endif
      if (ok) m_t = bcd2int(load_hh) * 3600 + bcd2int(load_mm) * 60 + bcd2int(load_ss);
      else if (adv) m_t = (m_t + 1) % 86400;
      m_sec = adv && !ok;
      m_day = m_sec && (m_t == 0);
      m_err = acc && !ok;
      m_ready = 1'b1;
      m_changed = m_sec || ok;
    end
    m_s3 = m_s2;
    m_s2 = m_s1;
    m_s1 = tick_1Hz;
  endtask

  task automatic cycle();
    @(posedge clk_50MHz);
    model_step();
    @(negedge clk_50MHz);
    check_val("hh", hh_bcd, to_bcd(m_t / 3600));
    check_val("mm", mm_bcd, to_bcd((m_t / 60) % 60));
    check_val("ss", ss_bcd, to_bcd(m_t % 60));
    check_val("sec_pulse", sec_pulse, m_sec);
    check_val("day_pulse", day_pulse, m_day);
    check_val("load_err", load_err, m_err);
    check_val("load_ready", load_ready, m_ready);
    check_val("alarm_ring", alarm_ring, m_ring);
  endtask

  task automatic rise(input int hi, input int lo);
    tick_1Hz = 1'b1;
    repeat (hi) cycle();
    tick_1Hz = 1'b0;
    repeat (lo) cycle();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_valid = 1'b1;
    load_hh = h;
    load_mm = m;
    load_ss = s;
    cycle();
    $display("load %h:%h:%h -> time %h:%h:%h err=%0d", h, m, s, hh_bcd, mm_bcd, ss_bcd, load_err);
    load_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick_1Hz = 1'b0; load_valid = 1'b0;
    load_hh = '0; load_mm = '0; load_ss = '0;
    alarm_wr = 1'b0; alarm_hh = '0; alarm_mm = '0; alarm_on = 1'b0; alarm_ack = 1'b0;
    m_s1 = 0; m_s2 = 0; m_s3 = 0; m_since = 0; m_t = 0;
    {m_ready, m_sec, m_day, m_err, m_ring, m_changed} = '0;
    m_ahh = 0; m_amm = 0;

    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    // Three plain seconds from reset.
    repeat (3) rise(4, 4);

    // Midnight rollover.
    do_load(8'h23, 8'h59, 8'h58);
    repeat (2) rise(4, 4);

    // Rejected loads.
    do_load(8'h12, 8'h60, 8'h00);
    cycle();
    do_load(8'h1A, 8'h00, 8'h00);
    cycle();

    // Legal load landing on the same edge as a detected rise.
    tick_1Hz = 1'b1;
    repeat (2) cycle();
    do_load(8'h10, 8'h20, 8'h30);
    repeat (4) cycle();
    tick_1Hz = 1'b0;
    repeat (3) cycle();

    // Reset while a rise is still in the synchronizer, tick held high afterwards.
    tick_1Hz = 1'b1;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (6) cycle();
    tick_1Hz = 1'b0;
    repeat (3) cycle();
    rise(4, 4);

    // Alarm at 07:00 reached from 06:59:59, then acknowledged.
    alarm_wr = 1'b1; alarm_hh = 8'h07; alarm_mm = 8'h00; alarm_on = 1'b1;
    cycle();
    alarm_wr = 1'b0;
    do_load(8'h06, 8'h59, 8'h59);
    rise(4, 8);
    alarm_ack = 1'b1;
    cycle();
    alarm_ack = 1'b0;
    repeat (3) cycle();

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 3) == 0) tick_1Hz = ~tick_1Hz;
      rst_n = ($urandom_range(0, 599) != 0);
      load_valid = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: begin
          load_hh = 8'($urandom); load_mm = 8'($urandom); load_ss = 8'($urandom);
        end
        1: begin
          load_hh = to_bcd($urandom_range(0, 23));
          load_mm = to_bcd($urandom_range(0, 59));
          load_ss = to_bcd($urandom_range(0, 59));
        end
        default: begin
          load_hh = 8'h23; load_mm = 8'h59; load_ss = to_bcd($urandom_range(50, 59));
        end
      endcase
      alarm_wr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) begin
        alarm_hh = load_hh; alarm_mm = to_bcd(bcd2int(load_mm) % 60 + 1 > 59 ? 0 : bcd2int(load_mm) % 60 + 1);
      end else begin
        alarm_hh = 8'($urandom); alarm_mm = 8'($urandom);
      end
      alarm_on = ($urandom_range(0, 15) != 0);
      alarm_ack = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
